arbitre_registre: RTL

- Round-robin arbiter sharing one WIDTH-bit register between NB_REQ requesters.
- The shared register is a bank of D flip-flops (Q/Qbar pairs).
- Requesters use a req/grant/ack handshake to load their data word; the arbiter sequences access so exactly one write reaches the register per transaction.
- Sits between write clients and the shared register in the memory library.

---
 rtl/arbitre_registre.sv | 103 ++++++++++
 1 files changed

// File: rtl/arbitre_registre.sv
// Round-robin arbiter that serialises writes from NB_REQ requesters into one
// shared WIDTH-bit register with complementary q/qn outputs.
module arbitre_registre #(
  parameter int NB_REQ = 4,
  parameter int WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NB_REQ-1:0]           req,
  input  logic [NB_REQ*WIDTH-1:0]     wdata,
  output logic [NB_REQ-1:0]           grant,
  output logic [NB_REQ-1:0]           ack,
  output logic [WIDTH-1:0]            q,
  output logic [WIDTH-1:0]            qn,
  output logic [$clog2(NB_REQ)-1:0]   owner,
  output logic                        busy,
  output logic [1:0]                  state_dbg
);

  localparam int IW = $clog2(NB_REQ);
  localparam logic [NB_REQ-1:0] ONE = NB_REQ'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, ACK = 2'd2} state_t;

  // Handshake: a requester raises req[i] with stable wdata and holds it until
  // ack[i] pulses; grant[i] marks ownership; dropping req[i] while granted
  // withdraws the request without a write.
  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   sel_c;
  logic            found_c;
  logic [IW-1:0]   idx;
  logic [WIDTH-1:0] wsel;

  // First set request at or after ptr, wrapping naturally in IW bits.
  always_comb begin
    sel_c   = ptr;
    found_c = 1'b0;
    idx     = ptr;
    for (int k = 0; k < NB_REQ; k++) begin
      idx = ptr + IW'(k);
      if (!found_c && req[idx]) begin
        sel_c   = idx;
        found_c = 1'b1;
      end
    end
  end

  always_comb begin
    wsel = wdata[int'(sel)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      ack   <= '0;
      q     <= '0;
      owner <= '0;
      ptr   <= '0;
      sel   <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (found_c) begin
            sel   <= sel_c;
            grant <= ONE << sel_c;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (req[sel]) begin
            q     <= wsel;
            ack   <= ONE << sel;
            owner <= sel;
            ptr   <= sel + 1'b1;
            state <= ACK;
          end else begin
            grant <= '0;
            state <= IDLE;
          end
        end
        ACK: begin
          grant <= '0;
          ack   <= '0;
          state <= IDLE;
        end
        default: begin
          grant <= '0;
          ack   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign qn        = ~q;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule
